// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller: issues instruction-memory reads, reports
// fetched PCs and handles jump/branch redirects with response discard.
module pc_fetch_ctrl #(
  parameter int                DATA_W   = 16,
  parameter int                PC_INC   = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              enable,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic [DATA_W-1:0] branch_pc,
  input  logic [DATA_W-1:0] jump_pc,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] current_pc,
  output logic              flush
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, REDIRECT} state_t;

  state_t                   state;
  logic [DATA_W-1:0]        pc;
  logic signed [DATA_W-1:0] target;
  logic                     redirect;

  function automatic logic [DATA_W-1:0] align_target(input logic signed [DATA_W-1:0] t);
    return {t[DATA_W-1:1], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] next_seq(input logic [DATA_W-1:0] p);
    return p + DATA_W'(PC_INC);
  endfunction

  assign redirect = (jump | branch_taken) && (state != IDLE);
  assign target   = jump ? $signed(jump_pc) : $signed(branch_pc);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      current_pc  <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      unique case (state)
        IDLE: begin
          imem_req <= 1'b0;
          if (enable) state <= FETCH;
        end
        FETCH: begin
          if (redirect) begin
            pc    <= align_target(target);
            flush <= 1'b1;
            // An un-acked request must finish on the bus before we move on.
            if (imem_req && !imem_ack) begin
              state <= DRAIN;
            end else begin
              imem_req <= 1'b0;
              state    <= REDIRECT;
            end
          end else if (imem_req) begin
            if (imem_ack) begin
              fetch_valid <= 1'b1;
              current_pc  <= pc;
              pc          <= next_seq(pc);
              imem_req    <= 1'b0;
              if (!enable) state <= IDLE;
            end
          end else if (!enable) begin
            state <= IDLE;
          end else if (!stall) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        DRAIN: begin
          if (redirect) begin
            pc    <= align_target(target);
            flush <= 1'b1;
          end
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= REDIRECT;
          end
        end
        REDIRECT: begin
          imem_req <= 1'b0;
          if (redirect) begin
            pc    <= align_target(target);
            flush <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios then randomized traffic, all
// checked against a transaction-level model of the fetch stream.
module tb_pc_fetch_ctrl;
  localparam int         W   = 16;
  localparam int         INC = 4;
  localparam logic [W-1:0] RPC = 16'h0000;

  logic         clk = 1'b0;
  logic         arst = 1'b0;
  logic         enable, stall, branch_taken, jump, imem_ack;
  logic         imem_req, fetch_valid, flush;
  logic [W-1:0] branch_pc, jump_pc, imem_addr, current_pc;

  int total = 0;
  int bad   = 0;

  // Reference model state: expected PC of next request, last reported PC.
  logic [W-1:0] m_pc, m_cpc;
  bit           m_active, m_discard;
  logic [W-1:0] issued[$];
  int           ack_mode;
  int           wait_cnt;

  pc_fetch_ctrl #(.DATA_W(W), .PC_INC(INC), .RESET_PC(RPC)) dut (
    .clk(clk), .arst(arst), .enable(enable), .stall(stall),
    .branch_taken(branch_taken), .jump(jump),
    .branch_pc(branch_pc), .jump_pc(jump_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .fetch_valid(fetch_valid), .current_pc(current_pc), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    if (imem_req && wait_cnt == 0) begin
      imem_ack = 1'b1;
      wait_cnt = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
    end else begin
      imem_ack = 1'b0;
      if (imem_req && wait_cnt > 0) wait_cnt--;
    end
  endtask

  task automatic step_clk();
    logic         rd, req_s, ack_s, stall_s, en_s, rst_s, exp_fv, exp_fl;
    logic [W-1:0] addr_s, tgt;
    rd      = jump | branch_taken;
    tgt     = jump ? jump_pc : branch_pc;
    tgt[0]  = 1'b0;
    req_s   = imem_req;
    ack_s   = imem_ack;
    stall_s = stall;
    en_s    = enable;
    addr_s  = imem_addr;
    rst_s   = arst;
    @(posedge clk);
    #1;
    if (rst_s) return;
    exp_fl = rd && m_active;
    exp_fv = 1'b0;
    if (req_s && ack_s) begin
      if (!m_discard && !rd) begin
        exp_fv = 1'b1;
        m_cpc  = addr_s;
        m_pc   = m_pc + W'(INC);
      end
      m_discard = 1'b0;
    end
    if (exp_fl) begin
      m_pc = tgt;
      if (req_s && !ack_s) m_discard = 1'b1;
    end
    if (en_s) m_active = 1'b1;
    chk1("fetch_valid", fetch_valid, exp_fv);
    chkw("current_pc", current_pc, m_cpc);
    chk1("flush", flush, exp_fl);
    if (req_s && !ack_s) begin
      chk1("req_hold", imem_req, 1'b1);
      chkw("addr_hold", imem_addr, addr_s);
    end
    if (!req_s && imem_req) begin
      chkw("req_addr", imem_addr, m_pc);
      chk1("issue_while_stall", stall_s, 1'b0);
      issued.push_back(imem_addr);
    end
    drive_mem();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chkw("rst_addr", imem_addr, RPC);
    chk1("rst_fv", fetch_valid, 1'b0);
    chk1("rst_flush", flush, 1'b0);
    chkw("rst_cpc", current_pc, RPC);
    @(posedge clk);
    #1;
    arst = 1'b0;
    imem_ack = 1'b0;
    jump = 1'b0;
    branch_taken = 1'b0;
    m_pc = RPC;
    m_cpc = RPC;
    m_active = 1'b0;
    m_discard = 1'b0;
    issued.delete();
    wait_cnt = (ack_mode < 0) ? 0 : ack_mode;
  endtask

  task automatic wait_issue(input int n);
    for (int i = 0; i < 40; i++) begin
      if (issued.size() >= n) break;
      step_clk();
    end
    chk1("issue_timeout", issued.size() >= n, 1'b1);
  endtask

  task automatic wait_outstanding();
    for (int i = 0; i < 40; i++) begin
      if (imem_req && !imem_ack) break;
      step_clk();
    end
  endtask

  initial begin
    int n;
    int r;
    enable = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_pc = '0; branch_pc = '0; imem_ack = 1'b0;
    ack_mode = 0; wait_cnt = 0;
    #2;
    do_reset();

    // Back-to-back fetches from reset with immediate ack
    enable = 1'b1;
    wait_issue(3);
    if (issued.size() >= 3) begin
      chkw("seq_addr0", issued[0], 16'h0000);
      chkw("seq_addr1", issued[1], 16'h0004);
      chkw("seq_addr2", issued[2], 16'h0008);
    end
    for (int i = 0; i < 4; i++) step_clk();

    // Slow memory with toggling back-pressure
    ack_mode = 3;
    for (int i = 0; i < 30; i++) begin
      stall = (i % 2 == 0);
      step_clk();
    end
    stall = 1'b1;
    for (int i = 0; i < 6; i++) step_clk();
    stall = 1'b0;

    // Branch while no request is outstanding
    ack_mode = 0;
    for (int i = 0; i < 40; i++) begin
      step_clk();
      if (fetch_valid && !imem_req) break;
    end
    branch_taken = 1'b1; branch_pc = 16'h0041;
    n = issued.size();
    step_clk();
    branch_taken = 1'b0;
    chk1("br_flush", flush, 1'b1);
    chk1("br_bubble", imem_req, 1'b0);
    wait_issue(n + 1);
    if (issued.size() > n) chkw("br_target", issued[n], 16'h0040);

    // Jump and branch together against an outstanding request
    ack_mode = 3;
    wait_issue(issued.size() + 2);
    wait_outstanding();
    jump = 1'b1; jump_pc = 16'h0100;
    branch_taken = 1'b1; branch_pc = 16'h0200;
    n = issued.size();
    step_clk();
    jump = 1'b0; branch_taken = 1'b0;
    chk1("jmp_flush", flush, 1'b1);
    chk1("drain_req_held", imem_req, 1'b1);
    wait_issue(n + 1);
    if (issued.size() > n) chkw("jmp_target", issued[n], 16'h0100);

    // PC wrap-around
    ack_mode = 0;
    jump = 1'b1; jump_pc = 16'hFFFC;
    n = issued.size();
    step_clk();
    jump = 1'b0;
    wait_issue(n + 2);
    if (issued.size() > n + 1) begin
      chkw("wrap_first", issued[n], 16'hFFFC);
      chkw("wrap_next", issued[n + 1], 16'h0000);
    end

    // Dropping enable mid-request completes it, then fetching stops
    ack_mode = 2;
    wait_issue(issued.size() + 2);
    wait_outstanding();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) step_clk();
    n = issued.size();
    for (int i = 0; i < 8; i++) step_clk();
    chk1("no_issue_disabled", issued.size() == n, 1'b1);
    enable = 1'b1;
    wait_issue(n + 2);

    // Reset in the middle of a request
    ack_mode = 3;
    wait_outstanding();
    do_reset();
    wait_issue(1);
    if (issued.size() > 0) chkw("post_rst_addr", issued[0], RPC);
    for (int i = 0; i < 10; i++) step_clk();

    // Randomized traffic
    ack_mode = -1;
    for (int i = 0; i < 800; i++) begin
      stall = ($urandom_range(0, 9) < 3);
      r = int'($urandom_range(0, 39));
      jump = (r == 0) || (r == 2);
      branch_taken = (r == 1) || (r == 2);
      jump_pc = W'($urandom);
      branch_pc = W'($urandom);
      step_clk();
      jump = 1'b0;
      branch_taken = 1'b0;
    end
    stall = 1'b0;
    for (int i = 0; i < 10; i++) step_clk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
